// File: rtl/nibble_serial_adder.sv
// Serial 32-bit adder that sums one nibble per clock, LSB nibble first, with a handshake on both ends.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN (adds the 'sub' input).
module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic        sub,
`endif
  output logic [31:0] result,
  output logic        carry_out,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SUM_W  = NIB_W + 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W / NIB_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_out_q, carry_out_d;
  logic                done_valid_q, done_valid_d;
  logic                start_ready_q, start_ready_d;
  logic                busy_q, busy_d;

  // Operation mode seen at the accept edge and the mode held for the running operation.
  logic                accept_sub;
  logic                run_sub;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign accept_sub = sub;
  assign run_sub    = sub_q;

  always_ff @(posedge clk) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == S_IDLE && start_valid) sub_d = accept_sub;
  end
`else
  assign accept_sub = 1'b0;
  assign run_sub    = 1'b0;
`endif

  // Current nibble adder; in subtract mode b is inverted and the carry was seeded with 1.
  logic [NIB_W-1:0] b_nib;
  logic [SUM_W-1:0] nib_sum;

  always_comb begin
    b_nib   = b_q[NIB_W-1:0] ^ {NIB_W{run_sub}};
    nib_sum = SUM_W'(a_q[NIB_W-1:0]) + SUM_W'(b_nib) + SUM_W'(carry_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      result_q      <= '0;
      carry_out_q   <= 1'b0;
      done_valid_q  <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sum_q         <= sum_d;
      result_q      <= result_d;
      carry_out_q   <= carry_out_d;
      done_valid_q  <= done_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
    end
  end

  // Operands shift right a nibble per RUN cycle; sum nibbles shift in from the top so the
  // first (least significant) nibble lands at bit 0 after the eighth step.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = accept_sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        sum_d   = {nib_sum[NIB_W-1:0], sum_q[DATA_W-1:NIB_W]};
        carry_d = nib_sum[NIB_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          result_d    = sum_d;
          carry_out_d = nib_sum[NIB_W];
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_d     = S_IDLE;
          result_d    = '0;
          carry_out_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        carry_d     = 1'b0;
        result_d    = '0;
        carry_out_d = 1'b0;
      end
    endcase

    done_valid_d  = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    start_ready_d = (state_d == S_IDLE);
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign done_valid  = done_valid_q;
  assign result      = result_q;
  assign carry_out   = carry_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder; define NIBBLE_SERIAL_ADDER_SUB_EN to cover subtract mode.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        carry_out;
  logic        done_valid;
  logic        done_ready;
  logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic        sub;
`endif

  int tests;
  int fails;

  nibble_serial_adder dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .result      (result),
    .carry_out   (carry_out),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then withdraw start_valid.
  task automatic accept(input logic [31:0] x, input logic [31:0] y);
    a = x; b = y; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  // Count edges after accept until done_valid; bounded so a stuck design still ends.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      if (done_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", result); end
    tests++; if (carry_out !== 1'b0) begin fails++; $display("FAIL reset_carry_out: got %b want 0", carry_out); end
  endtask

  // All-ones plus one wraps to zero; done_ready held high even while running.
  task automatic test_overflow();
    int edges;
    done_ready = 1'b1;
    accept(32'hFFFF_FFFF, 32'h0000_0001);
    tests++; if (busy !== 1'b1 || start_ready !== 1'b0) begin fails++; $display("FAIL ovf_after_accept: busy=%b start_ready=%b want 1/0", busy, start_ready); end
    wait_done(edges);
    tests++; if (edges != 8) begin fails++; $display("FAIL ovf_latency: got %0d edges want 8", edges); end
    tests++; if (result !== 32'h0000_0000) begin fails++; $display("FAIL ovf_result: got %h want 00000000", result); end
    tests++; if (carry_out !== 1'b1) begin fails++; $display("FAIL ovf_carry_out: got %b want 1", carry_out); end
    tick();
    tests++; if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ovf_handshake: dv=%b sr=%b busy=%b want 0/1/0", done_valid, start_ready, busy); end
    tests++; if (result !== 32'h0 || carry_out !== 1'b0) begin fails++; $display("FAIL ovf_cleared: result=%h co=%b want 0/0", result, carry_out); end
    done_ready = 1'b0;
  endtask

  // start_valid and scrambled operands during RUN must not disturb the captured operation.
  task automatic test_ignore_start();
    int edges;
    int bad_ready;
    done_ready = 1'b0;
    bad_ready  = 0;
    edges      = 0;
    a = 32'h1234_5678; b = 32'h1111_1111; start_valid = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      a = 32'hDEAD_BEEF + 32'(i); b = 32'hFFFF_FFFF;
      if (start_ready !== 1'b0) bad_ready++;
      tick();
      edges++;
      if (done_valid === 1'b1) break;
    end
    start_valid = 1'b0;
    tests++; if (bad_ready != 0) begin fails++; $display("FAIL ign_start_ready: got %0d cycles high want 0", bad_ready); end
    tests++; if (edges != 8) begin fails++; $display("FAIL ign_latency: got %0d edges want 8", edges); end
    tests++; if (result !== 32'h2345_6789 || carry_out !== 1'b0) begin fails++; $display("FAIL ign_result: got %h/%b want 23456789/0", result, carry_out); end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    tests++; if (start_ready !== 1'b1 || done_valid !== 1'b0) begin fails++; $display("FAIL ign_idle: sr=%b dv=%b want 1/0", start_ready, done_valid); end
  endtask

  // Consumer stalls five cycles; output must hold until the handshake edge.
  task automatic test_backpressure();
    int edges;
    int unstable;
    unstable   = 0;
    done_ready = 1'b0;
    accept(32'h0000_000F, 32'h0000_0001);
    wait_done(edges);
    tests++; if (edges != 8) begin fails++; $display("FAIL bp_latency: got %0d edges want 8", edges); end
    for (int i = 0; i < 5; i++) begin
      if (result !== 32'h0000_0010 || carry_out !== 1'b0 || done_valid !== 1'b1 || busy !== 1'b1) unstable++;
      tick();
    end
    tests++; if (unstable != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
    tests++; if (result !== 32'h0000_0010 || done_valid !== 1'b1) begin fails++; $display("FAIL bp_still_done: got %h/%b want 00000010/1", result, done_valid); end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    tests++; if (done_valid !== 1'b0 || start_ready !== 1'b1 || result !== 32'h0) begin fails++; $display("FAIL bp_release: dv=%b sr=%b res=%h want 0/1/0", done_valid, start_ready, result); end
  endtask

  // Reset on the fourth RUN edge discards the operation; a fresh one then completes.
  task automatic test_mid_run_reset();
    int edges;
    int pulses;
    pulses     = 0;
    done_ready = 1'b0;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || result !== 32'h0 || carry_out !== 1'b0) begin fails++; $display("FAIL rr_idle: sr=%b busy=%b dv=%b res=%h co=%b want 1/0/0/0/0", start_ready, busy, done_valid, result, carry_out); end
    for (int i = 0; i < 12; i++) begin
      if (done_valid !== 1'b0) pulses++;
      tick();
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL rr_no_pulse: got %0d done cycles want 0", pulses); end
    accept(32'd3, 32'd4);
    wait_done(edges);
    tests++; if (edges != 8 || result !== 32'h0000_0007 || carry_out !== 1'b0) begin fails++; $display("FAIL rr_new_op: edges=%0d res=%h co=%b want 8/00000007/0", edges, result, carry_out); end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    rst = 1'b1;
    a = 32'h1; b = 32'h1; start_valid = 1'b1;
    tick();
    rst = 1'b0; start_valid = 1'b0;
    tests++; if (busy !== 1'b0 || start_ready !== 1'b1) begin fails++; $display("FAIL rr_priority: busy=%b sr=%b want 0/1", busy, start_ready); end
  endtask

  // Two operations at full rate: handshake edge 9 after accept, next accept possible on edge 10.
  task automatic test_back_to_back();
    int edges;
    done_ready = 1'b1;
    accept(32'h8000_0000, 32'h8000_0000);
    wait_done(edges);
    tests++; if (edges != 8 || result !== 32'h0 || carry_out !== 1'b1) begin fails++; $display("FAIL b2b_first: edges=%0d res=%h co=%b want 8/00000000/1", edges, result, carry_out); end
    tick();
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", start_ready); end
    accept(32'h0F0F_0F0F, 32'h0101_0101);
    wait_done(edges);
    tests++; if (edges != 8 || result !== 32'h1010_1010 || carry_out !== 1'b0) begin fails++; $display("FAIL b2b_second: edges=%0d res=%h co=%b want 8/10101010/0", edges, result, carry_out); end
    tick();
    done_ready = 1'b0;
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int edges;
    done_ready = 1'b1;
    sub = 1'b1;
    accept(32'd5, 32'd7);
    sub = 1'b0;
    wait_done(edges);
    tests++; if (edges != 8 || result !== 32'hFFFF_FFFE || carry_out !== 1'b0) begin fails++; $display("FAIL sub_5_7: edges=%0d res=%h co=%b want 8/fffffffe/0", edges, result, carry_out); end
    tick();
    sub = 1'b1;
    accept(32'd7, 32'd5);
    sub = 1'b0;
    wait_done(edges);
    tests++; if (edges != 8 || result !== 32'h0000_0002 || carry_out !== 1'b1) begin fails++; $display("FAIL sub_7_5: edges=%0d res=%h co=%b want 8/00000002/1", edges, result, carry_out); end
    tick();
    accept(32'd5, 32'd7);
    wait_done(edges);
    tests++; if (result !== 32'h0000_000C || carry_out !== 1'b0) begin fails++; $display("FAIL sub_off_add: res=%h co=%b want 0000000c/0", result, carry_out); end
    tick();
    done_ready = 1'b0;
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_overflow();
    test_ignore_start();
    test_backpressure();
    test_mid_run_reset();
    test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start_valid  input  1  operands on a/b are valid this cycle.
REQ-005 start_ready  output  1  block can accept operands (high only in IDLE).
REQ-006 a  input  32  first operand, sampled on the accept edge.
REQ-007 b  input  32  second operand, sampled on the accept edge.
REQ-008 result  output  32  sum, valid while done_valid is high.
REQ-009 carry_out  output  1  carry out of bit 31, valid while done_valid is high.
REQ-010 done_valid  output  1  result/carry_out available.
REQ-011 done_ready  input  1  consumer takes the result this cycle.
REQ-012 busy  output  1  high in RUN and DONE.

Function
REQ-013 SHALL compute a 32-bit add one 4-bit nibble per cycle, least significant nibble first, with a 1-bit carry register chaining nibbles.
REQ-014 States SHALL be IDLE, RUN and DONE, with a 3-bit nibble counter.
REQ-015 Accept: on a rising edge in IDLE with start_valid=1 -> capture a and b, clear result, set carry to its initial value, set counter to 0, go to RUN.
REQ-016 In RUN, each edge SHALL write {cnt}-th nibble = a_nib + b_nib + carry (low 4 bits), set carry = bit 4, and increment the counter.
REQ-017 After the edge that processes counter 7 -> go to DONE, with carry_out = final carry.
REQ-018 Latency SHALL be exactly 8 cycles: done_valid rises on the 8th edge after the accept edge.
REQ-019 DONE: done_valid=1, and result/carry_out SHALL stay stable until the handshake; on an edge with done_ready=1 -> go to IDLE and drop done_valid.
REQ-020 start_valid SHALL be ignored in RUN and DONE; changes on a/b after accept SHALL not affect the result.
REQ-021 done_ready SHALL be ignored outside DONE.
REQ-022 Maximum throughput SHALL be one operation per 10 cycles (accept, 8 RUN, DONE/handshake).
REQ-023 Arithmetic SHALL be modulo 2^32; the carry beyond bit 31 appears only on carry_out.
REQ-024 result and carry_out SHALL read 0 whenever done_valid=0.

Reset
REQ-025 rst=1 on an edge SHALL force IDLE, counter=0, carry=0, result=0, carry_out=0, done_valid=0, busy=0, start_ready=1 on the following cycle.
REQ-026 rst SHALL take priority over all other inputs, including mid-RUN and mid-DONE; any in-flight operation is discarded with no done_valid pulse.

Configuration
REQ-027 Macro NIBBLE_SERIAL_ADDER_SUB_EN, when defined, SHALL add input port sub (1 bit), sampled on the accept edge.
REQ-028 With the macro defined and sub=1: b SHALL be inverted per nibble, initial carry SHALL be 1, result = a - b mod 2^32, and carry_out=1 means no borrow. With sub=0 the block SHALL behave as the add-only build.
REQ-029 Without the macro, the sub port SHALL be absent, the block SHALL only add, and the initial carry SHALL be 0.

Verification
REQ-030 a=0xFFFFFFFF, b=0x00000001, then accept -> done_valid 8 cycles later, result=0x00000000, carry_out=1.
REQ-031 a=0x12345678, b=0x11111111 -> result=0x23456789, carry_out=0; start_valid=1 held throughout RUN has no effect and start_ready=0.
REQ-032 a=0x0000000F, b=0x00000001, done_ready held low 5 cycles -> result=0x00000010 held stable and done_valid held high; IDLE on the edge after done_ready=1.
REQ-033 rst asserted on the 4th RUN edge -> next cycle in IDLE with result=0 and done_valid=0, no done_valid pulse; a new operation 3+4 then gives 0x00000007.
REQ-034 NIBBLE_SERIAL_ADDER_SUB_EN defined: a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry_out=0; a=7, b=5, sub=1 -> result=0x00000002, carry_out=1.
